mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory stage directly downstream of the execute ALU. It consumes the ALU result as a pass-through value or as a load/store address.
//  Load/store ops go through a req/gnt/rvalid data bus, with store byte-lane alignment and load extraction/sign-extension.
//  Delivers one registered writeback record per accepted op to the WB stage; stalls execute via ex_ready while a memory access is in flight.
// PARAMETERS
//  XLEN      64  register/data width (only 64 supported)
//  BUS_BYTES 8   data-bus width in bytes; mem_addr is BUS_BYTES-aligned
// PORTS
//  clk           in   1     clock
//  rst           in   1     reset, synchronous, active-low (0 = reset)
//  ex_valid      in   1     execute presents an op
//  ex_ready      out  1     stage can accept (handshake = ex_valid & ex_ready)
//  ex_alu_result in   64    ALU output: result or effective address
//  ex_store_data in   64    rs2 value for stores
//  ex_is_load    in   1     op is a load
//  ex_is_store   in   1     op is a store (never both with load)
//  ex_size       in   2     0=B 1=H 2=W 3=D
//  ex_unsigned   in   1     zero-extend load (LBU/LHU/LWU)
//  ex_rd         in   5     destination register
//  ex_rd_wen     in   1     op writes rd
//  mem_req       out  1     bus request
//  mem_we        out  1     1 = write
//  mem_addr      out  64    {addr[63:3],3'b0}
//  mem_wdata     out  64    lane-shifted store data
//  mem_wmask     out  8     byte enables
//  mem_gnt       in   1     bus accepted request this cycle
//  mem_rvalid    in   1     read data valid (never in the gnt cycle)
//  mem_rdata     in   64    read data, full bus word
//  wb_valid      out  1     one-cycle pulse: record valid
//  wb_rd         out  5     destination
//  wb_wen        out  1     write rd (0 for stores)
//  wb_data       out  64    writeback value
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state=IDLE; every output register cleared; wb_valid=0, mem_req=0, mem_we=0, mem_addr/wdata/wmask=0, wb_rd/wb_wen/wb_data=0. Any in-flight access is abandoned with no WB record; a late mem_rvalid after reset is ignored.
//  FSM IDLE/REQ/WAIT; ex_ready = (state==IDLE).
//  IDLE, handshake, non-mem op: next cycle wb_valid=1, wb_data=ex_alu_result, wb_rd/wb_wen from ex. Stay IDLE. Latency 1, throughput 1/cycle.
//  IDLE, handshake, load/store: latch op; drive mem_* registered; -> REQ (mem_req=1 from the next cycle).
//  REQ: hold mem_req and all mem_* stable until mem_gnt.
//   gnt & store: mem_req=0; wb_valid=1 next cycle with wb_wen=0; -> IDLE.
//   gnt & load: mem_req=0; -> WAIT.
//  WAIT: on mem_rvalid, sh = 8*addr[2:0]; v = mem_rdata>>sh; take low 8/16/32/64 bits by size; sign-extend unless ex_unsigned (D ignores it).
//   Next cycle: wb_valid=1, wb_data=v, wb_wen=ex_rd_wen; -> IDLE.
//  Memory-op latency: issue 1 cycle + gnt wait + rvalid wait (load) + 1 cycle.
//  Store: mem_wmask=((1<<(1<<size))-1)<<addr[2:0] truncated to 8 bits; mem_wdata=ex_store_data<<sh.
//  wb_* are registered and have no backpressure. wb_valid is low in every cycle without a completing op.
//  ex_rd=0 with ex_rd_wen=1 is forwarded unchanged; WB discards it.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - A load/store where addr is not a multiple of (1<<size) is never issued; mem_req stays 0.
//   - Next cycle: wb_valid=1, wb_wen=0, wb_data=address, and extra output wb_misalign=1 (1-bit port, present only with the macro).
//   - State stays IDLE.
//  Macro undefined:
//   - No check is done and the wb_misalign port does not exist.
//   - The access is issued as-is. Lanes past byte 7 are dropped from mem_wmask/mem_wdata; load bytes past byte 7 read as 0 before extension.
// TESTING
//  1. ADD result 0x1234, rd=5, wen=1, no mem op -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; ex_ready stays 1 for back-to-back ops.
//  2. LB addr 0x1003, rdata=0x00000000_80000000, gnt and rvalid 1 cycle each -> wb_data=0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
//  3. SW addr 0x1004, data 0xDEADBEEF -> mem_addr=0x1000, wmask=0xF0, wdata=0xDEADBEEF_00000000, we=1; wb_wen=0.
//  4. LD, gnt delayed 3 cycles -> mem_req and mem_addr stable 3 cycles, ex_ready=0 throughout, exactly one wb_valid pulse.
//  5. rst=0 during WAIT, then rvalid arrives -> all outputs 0, no wb_valid, next op handled normally.
//  6. With MEM_MISALIGN_TRAP_EN: LW addr 0x1002 -> no mem_req, wb_misalign=1, wb_data=0x1002. Without the macro: access issued with mem_wmask/lanes truncated.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory stage: forwards ALU results or runs one load/store over a req/gnt/rvalid bus,
// producing a registered writeback record. Optional `MEM_MISALIGN_TRAP_EN adds misaligned-access trapping.
module mem_stage_lsu #(
    parameter int XLEN      = 64,
    parameter int BUS_BYTES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [XLEN-1:0]        ex_alu_result,
    input  logic [XLEN-1:0]        ex_store_data,
    input  logic                   ex_is_load,
    input  logic                   ex_is_store,
    input  logic [1:0]             ex_size,
    input  logic                   ex_unsigned,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_rd_wen,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [BUS_BYTES-1:0]   mem_wmask,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   wb_valid,
    output logic [4:0]             wb_rd,
    output logic                   wb_wen,
    output logic [XLEN-1:0]        wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                   wb_misalign
`endif
);

    localparam int OFF_W = $clog2(BUS_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    // Op fields kept for the response phase while ex_* moves on.
    logic [1:0]       op_size_q, op_size_d;
    logic             op_unsigned_q, op_unsigned_d;
    logic [OFF_W-1:0] op_off_q, op_off_d;
    logic [4:0]       op_rd_q, op_rd_d;
    logic             op_rd_wen_q, op_rd_wen_d;

    logic                 mem_req_d, mem_we_d;
    logic [XLEN-1:0]      mem_addr_d, mem_wdata_d;
    logic [BUS_BYTES-1:0] mem_wmask_d;
    logic                 wb_valid_d, wb_wen_d;
    logic [4:0]           wb_rd_d;
    logic [XLEN-1:0]      wb_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 wb_misalign_d;
    logic                 misaligned;
`endif

    logic [OFF_W-1:0]       ex_off;
    logic                   ex_is_mem;
    logic [BUS_BYTES-1:0]   size_mask;
    logic [2*BUS_BYTES-1:0] wide_mask;
    logic [XLEN-1:0]        load_value;

    assign ex_ready  = (state_q == S_IDLE);
    assign ex_off    = ex_alu_result[OFF_W-1:0];
    assign ex_is_mem = ex_is_load | ex_is_store;

    always_comb begin
        case (ex_size)
            2'd0:    size_mask = BUS_BYTES'(8'h01);
            2'd1:    size_mask = BUS_BYTES'(8'h03);
            2'd2:    size_mask = BUS_BYTES'(8'h0F);
            default: size_mask = BUS_BYTES'(8'hFF);
        endcase
    end

    // Lanes shifted past the top byte fall into the upper half and are dropped.
    assign wide_mask = {{BUS_BYTES{1'b0}}, size_mask} << ex_off;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        case (ex_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = ex_off[0];
            2'd2:    misaligned = |ex_off[1:0];
            default: misaligned = |ex_off;
        endcase
    end
`endif

    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0]  rdata,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size,
        input logic             is_unsigned
    );
        logic [XLEN-1:0] v;
        v = rdata >> {off, 3'b000};
        case (size)
            2'd0:    load_extract = is_unsigned ? {{(XLEN-8){1'b0}}, v[7:0]}
                                                : {{(XLEN-8){v[7]}}, v[7:0]};
            2'd1:    load_extract = is_unsigned ? {{(XLEN-16){1'b0}}, v[15:0]}
                                                : {{(XLEN-16){v[15]}}, v[15:0]};
            2'd2:    load_extract = is_unsigned ? {{(XLEN-32){1'b0}}, v[31:0]}
                                                : {{(XLEN-32){v[31]}}, v[31:0]};
            default: load_extract = v;
        endcase
    endfunction

    assign load_value = load_extract(mem_rdata, op_off_q, op_size_q, op_unsigned_q);

    // NOTE: every always_comb target gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d       = state_q;
        op_size_d     = op_size_q;
        op_unsigned_d = op_unsigned_q;
        op_off_d      = op_off_q;
        op_rd_d       = op_rd_q;
        op_rd_wen_d   = op_rd_wen_q;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_wmask_d   = mem_wmask;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd;
        wb_wen_d      = wb_wen;
        wb_data_d     = wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
        wb_misalign_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (ex_valid && !ex_is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = ex_rd;
                    wb_wen_d   = ex_rd_wen;
                    wb_data_d  = ex_alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
                end else if (ex_valid && misaligned) begin
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = ex_rd;
                    wb_wen_d      = 1'b0;
                    wb_data_d     = ex_alu_result;
                    wb_misalign_d = 1'b1;
`endif
                end else if (ex_valid) begin
                    op_size_d     = ex_size;
                    op_unsigned_d = ex_unsigned;
                    op_off_d      = ex_off;
                    op_rd_d       = ex_rd;
                    op_rd_wen_d   = ex_rd_wen;
                    mem_req_d     = 1'b1;
                    mem_we_d      = ex_is_store;
                    mem_addr_d    = {ex_alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    mem_wdata_d   = ex_is_store ? (ex_store_data << {ex_off, 3'b000}) : '0;
                    mem_wmask_d   = ex_is_store ? wide_mask[BUS_BYTES-1:0] : '0;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = op_rd_q;
                        wb_wen_d   = 1'b0;
                        wb_data_d  = '0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = op_rd_q;
                    wb_wen_d   = op_rd_wen_q;
                    wb_data_d  = load_value;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_size_q     <= '0;
            op_unsigned_q <= 1'b0;
            op_off_q      <= '0;
            op_rd_q       <= '0;
            op_rd_wen_q   <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_wen        <= 1'b0;
            wb_data       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_misalign   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_size_q     <= op_size_d;
            op_unsigned_q <= op_unsigned_d;
            op_off_q      <= op_off_d;
            op_rd_q       <= op_rd_d;
            op_rd_wen_q   <= op_rd_wen_d;
            mem_req       <= mem_req_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
            mem_wmask     <= mem_wmask_d;
            wb_valid      <= wb_valid_d;
            wb_rd         <= wb_rd_d;
            wb_wen        <= wb_wen_d;
            wb_data       <= wb_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_misalign   <= wb_misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed and randomized ALU, load and store ops
// against a byte-level reference model; also exercises reset mid-access and misalignment.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [63:0] ex_alu_result, ex_store_data;
    logic        ex_is_load, ex_is_store;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [63:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        wb_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .wb_misalign(wb_misalign)
`endif
    );

    // Reference model: byte-by-byte view of the bus word.
    function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                               input int sz, input bit uns);
        int nbytes = 1 << sz;
        int off = int'(addr[2:0]);
        logic [63:0] v = '0;
        for (int i = 0; i < nbytes; i++)
            if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!uns && nbytes < 8 && v[8*nbytes-1])
            for (int i = nbytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_mask(input logic [63:0] addr, input int sz);
        logic [7:0] m = '0;
        int off = int'(addr[2:0]);
        for (int i = 0; i < (1 << sz); i++)
            if (off + i < 8) m[off+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] data, input logic [63:0] addr);
        logic [63:0] w = '0;
        int off = int'(addr[2:0]);
        for (int j = 0; j + off < 8; j++) w[8*(j+off) +: 8] = data[8*j +: 8];
        return w;
    endfunction

    function automatic logic [63:0] legal_addr(input logic [63:0] a, input int sz);
`ifdef MEM_MISALIGN_TRAP_EN
        return a & ~((64'd1 << sz) - 64'd1);
`else
        return a;
`endif
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_is_load = 0; ex_is_store = 0;
        ex_size = 0; ex_unsigned = 0; ex_rd = 0; ex_rd_wen = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    // Presents one op for exactly one cycle; returns #1 after the accepting edge.
    task automatic drive_op(input logic [63:0] a, input logic [63:0] sd, input bit ld, input bit st,
                            input int sz, input bit uns, input logic [4:0] rd, input bit wen,
                            input string nm);
        ex_valid = 1; ex_alu_result = a; ex_store_data = sd; ex_is_load = ld; ex_is_store = st;
        ex_size = 2'(sz); ex_unsigned = uns; ex_rd = rd; ex_rd_wen = wen;
        if (ex_ready !== 1'b1) begin failures++; $display("FAIL %s ex_ready before issue: got %b expected 1", nm, ex_ready); end
        checks++;
        @(posedge clk); #1;
        ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
    endtask

    task automatic run_mem_op(input logic [63:0] a, input logic [63:0] sd, input bit st, input int sz,
                              input bit uns, input logic [4:0] rd, input bit wen, input logic [63:0] rdata,
                              input int gnt_dly, input int rv_dly, input string nm);
        logic [63:0] exp_addr = a & ~64'h7;
        drive_op(a, sd, !st, st, sz, uns, rd, wen, nm);
        if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== exp_addr) begin
            failures++;
            $display("FAIL %s issue: req=%b we=%b addr=%h expected req=1 we=%b addr=%h", nm, mem_req, mem_we, mem_addr, st, exp_addr);
        end
        checks++;
        if (st) begin
            if (mem_wmask !== model_mask(a, sz) || mem_wdata !== model_wdata(sd, a)) begin
                failures++;
                $display("FAIL %s store lanes: wmask=%h wdata=%h expected wmask=%h wdata=%h", nm, mem_wmask, mem_wdata, model_mask(a, sz), model_wdata(sd, a));
            end
            checks++;
        end
        for (int i = 0; i < gnt_dly; i++) begin
            @(posedge clk); #1;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s gnt wait %0d: req=%b addr=%h ready=%b wb_valid=%b expected 1 %h 0 0", nm, i, mem_req, mem_addr, ex_ready, wb_valid, exp_addr);
            end
            checks++;
        end
        mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL %s req after gnt: got %b expected 0", nm, mem_req); end
        checks++;
        if (st) begin
            if (wb_valid !== 1'b1 || wb_wen !== 1'b0 || wb_rd !== rd) begin
                failures++;
                $display("FAIL %s store wb: valid=%b wen=%b rd=%0d expected 1 0 %0d", nm, wb_valid, wb_wen, wb_rd, rd);
            end
            checks++;
        end else begin
            for (int i = 0; i <= rv_dly; i++) begin
                if (wb_valid !== 1'b0 || ex_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s rvalid wait %0d: wb_valid=%b ready=%b expected 0 0", nm, i, wb_valid, ex_ready);
                end
                checks++;
                if (i < rv_dly) begin @(posedge clk); #1; end
            end
            mem_rvalid = 1; mem_rdata = rdata;
            @(posedge clk); #1;
            mem_rvalid = 0; mem_rdata = {$urandom, $urandom};
            if (wb_valid !== 1'b1 || wb_data !== model_load(rdata, a, sz, uns) || wb_wen !== wen || wb_rd !== rd) begin
                failures++;
                $display("FAIL %s load wb: valid=%b data=%h wen=%b rd=%0d expected 1 %h %b %0d", nm, wb_valid, wb_data, wb_wen, wb_rd, model_load(rdata, a, sz, uns), wen, rd);
            end
            checks++;
        end
        @(posedge clk); #1;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s after completion: wb_valid=%b ready=%b expected 0 1", nm, wb_valid, ex_ready);
        end
        checks++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        if ({wb_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, wb_rd, wb_wen, wb_data} !== '0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset state: wb_valid=%b req=%b we=%b addr=%h wdata=%h wmask=%h rd=%0d wen=%b data=%h ready=%b", wb_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, wb_rd, wb_wen, wb_data, ex_ready);
        end
        checks++;
        rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_back_to_back();
        logic [63:0] res;
        logic [4:0]  rd;
        bit          wen;
        drive_op(64'h1234, '0, 0, 0, 0, 0, 5'd5, 1, "add");
        if (wb_valid !== 1'b1 || wb_data !== 64'h1234 || wb_rd !== 5'd5 || wb_wen !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL add: valid=%b data=%h rd=%0d wen=%b req=%b expected 1 1234 5 1 0", wb_valid, wb_data, wb_rd, wb_wen, mem_req);
        end
        checks++;
        for (int i = 0; i < 20; i++) begin
            res = {$urandom, $urandom}; rd = 5'($urandom); wen = 1'($urandom);
            if (i == 3) begin rd = 5'd0; wen = 1; end
            ex_valid = 1; ex_alu_result = res; ex_is_load = 0; ex_is_store = 0; ex_rd = rd; ex_rd_wen = wen;
            if (ex_ready !== 1'b1) begin failures++; $display("FAIL b2b ready %0d: got %b expected 1", i, ex_ready); end
            checks++;
            @(posedge clk); #1;
            if (wb_valid !== 1'b1 || wb_data !== res || wb_rd !== rd || wb_wen !== wen) begin
                failures++;
                $display("FAIL b2b wb %0d: valid=%b data=%h rd=%0d wen=%b expected 1 %h %0d %b", i, wb_valid, wb_data, wb_rd, wb_wen, res, rd, wen);
            end
            checks++;
        end
        ex_valid = 0;
        @(posedge clk); #1;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL b2b idle: wb_valid=%b expected 0", wb_valid); end
        checks++;
    endtask

    task automatic test_load();
        run_mem_op(64'h1003, '0, 0, 0, 0, 5'd7, 1, 64'h00000000_80000000, 0, 0, "lb");
        run_mem_op(64'h1003, '0, 0, 0, 1, 5'd7, 1, 64'h00000000_80000000, 0, 0, "lbu");
        if (wb_data !== 64'h80) begin failures++; $display("FAIL lbu const: got %h expected 80", wb_data); end
        checks++;
        for (int i = 0; i < 16; i++) begin
            int sz = int'($urandom_range(0, 3));
            run_mem_op(legal_addr({$urandom, $urandom}, sz), '0, 0, sz, 1'($urandom), 5'($urandom), 1'($urandom),
                       {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand_load");
        end
    endtask

    task automatic test_store();
        run_mem_op(64'h1004, 64'hDEADBEEF, 1, 2, 0, 5'd3, 1, '0, 0, 0, "sw");
        if (mem_addr !== 64'h1000 || mem_wmask !== 8'hF0 || mem_wdata !== 64'hDEADBEEF_00000000 || mem_we !== 1'b1) begin
            failures++;
            $display("FAIL sw const: addr=%h wmask=%h wdata=%h we=%b expected 1000 f0 deadbeef00000000 1", mem_addr, mem_wmask, mem_wdata, mem_we);
        end
        checks++;
        for (int i = 0; i < 12; i++) begin
            int sz = int'($urandom_range(0, 3));
            run_mem_op(legal_addr({$urandom, $urandom}, sz), {$urandom, $urandom}, 1, sz, 0, 5'($urandom), 1,
                       '0, int'($urandom_range(0, 3)), 0, "rand_store");
        end
    endtask

    task automatic test_gnt_delay();
        run_mem_op(64'h2008, '0, 0, 3, 0, 5'd9, 1, 64'hFEDC_BA98_7654_3210, 3, 2, "ld_gnt3");
    endtask

    task automatic test_reset_in_wait();
        drive_op(64'h3000, '0, 1, 0, 3, 0, 5'd4, 1, "rst_wait");
        mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        if ({wb_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, wb_rd, wb_wen, wb_data} !== '0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait outputs: wb_valid=%b req=%b addr=%h rd=%0d data=%h ready=%b expected all 0, ready 1", wb_valid, mem_req, mem_addr, wb_rd, wb_data, ex_ready);
        end
        checks++;
        mem_rvalid = 1; mem_rdata = 64'h5555;
        @(posedge clk); #1;
        mem_rvalid = 0;
        if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wait late rvalid: wb_valid=%b expected 0", wb_valid); end
        checks++;
        drive_op(64'hABCD, '0, 0, 0, 0, 0, 5'd2, 1, "after_rst");
        if (wb_valid !== 1'b1 || wb_data !== 64'hABCD || wb_rd !== 5'd2) begin
            failures++;
            $display("FAIL after_rst: valid=%b data=%h rd=%0d expected 1 abcd 2", wb_valid, wb_data, wb_rd);
        end
        checks++;
        run_mem_op(64'h3010, '0, 0, 1, 0, 5'd6, 1, 64'h0000_0000_0000_8001, 1, 1, "after_rst_lh");
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        drive_op(64'h1002, '0, 1, 0, 2, 0, 5'd8, 1, "lw_misalign");
        if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_misalign !== 1'b1 || wb_data !== 64'h1002 || wb_wen !== 1'b0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL lw_misalign: req=%b valid=%b mis=%b data=%h wen=%b ready=%b expected 0 1 1 1002 0 1", mem_req, wb_valid, wb_misalign, wb_data, wb_wen, ex_ready);
        end
        checks++;
        drive_op(64'h77, '0, 0, 0, 0, 0, 5'd1, 1, "after_misalign");
        if (wb_valid !== 1'b1 || wb_misalign !== 1'b0 || wb_data !== 64'h77) begin
            failures++;
            $display("FAIL after_misalign: valid=%b mis=%b data=%h expected 1 0 77", wb_valid, wb_misalign, wb_data);
        end
        checks++;
`else
        run_mem_op(64'h1006, 64'hAABBCCDD, 1, 2, 0, 5'd8, 1, '0, 0, 0, "sw_trunc");
        if (mem_wmask !== 8'hC0 || mem_wdata !== 64'hCCDD_0000_0000_0000) begin
            failures++;
            $display("FAIL sw_trunc const: wmask=%h wdata=%h expected c0 ccdd000000000000", mem_wmask, mem_wdata);
        end
        checks++;
        run_mem_op(64'h1006, '0, 0, 2, 0, 5'd8, 1, 64'h1122_3344_5566_7788, 0, 0, "lw_trunc");
        if (wb_data !== 64'h1122) begin failures++; $display("FAIL lw_trunc const: got %h expected 1122", wb_data); end
        checks++;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load();
        test_store();
        test_gnt_delay();
        test_reset_in_wait();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
